// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between four clients and the round-robin arbiter.
// The master side drives requests and the slave side (the arbiter) returns the registered grant.
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid, input timeout);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid, output timeout);
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a hold limit; grant registered 1 cycle after request.
// No backpressure: a contended owner is forced off after MAX_HOLD cycles, an uncontended one keeps it.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter_4_if.slave bus
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_GRANT = 1'b1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

  // Returns {found, index}; the lowest offset from start wins because it is applied last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      cand = start + 2'(k);
      if (r[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [1:0]       idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             to_q, to_d;
  logic [3:0]       others;
  logic [2:0]       pick_rel, pick_rot;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    hold_d   = hold_q;
    idx_d    = idx_q;
    vld_d    = vld_q;
    to_d     = 1'b0;
    others   = bus.req & ~(4'b0001 << idx_q);
    pick_rel = rr_pick(bus.req, last_q + 2'd1);
    pick_rot = rr_pick(others, idx_q + 2'd1);

    case (state_q)
      ST_IDLE: begin
        if (pick_rel[2]) begin
          state_d = ST_GRANT;
          idx_d   = pick_rel[1:0];
          last_d  = pick_rel[1:0];
          vld_d   = 1'b1;
          hold_d  = '0;
        end else begin
          idx_d = 2'd0;
          vld_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!bus.req[idx_q]) begin
          // Owner released: the owner's own bit is already clear, so search all requests.
          if (pick_rel[2]) begin
            idx_d  = pick_rel[1:0];
            last_d = pick_rel[1:0];
            hold_d = '0;
          end else begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            vld_d   = 1'b0;
            hold_d  = '0;
          end
        end else if (hold_q == HOLD_LIM && others != 4'b0000) begin
          idx_d  = pick_rot[1:0];
          last_d = pick_rot[1:0];
          hold_d = '0;
          to_d   = 1'b1;
        end else if (hold_q != HOLD_LIM) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    gnt_d = vld_d ? (4'b0001 << idx_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 2'd3;
      hold_q  <= '0;
      idx_q   <= 2'd0;
      vld_q   <= 1'b0;
      gnt_q   <= 4'b0000;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      gnt_q   <= gnt_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = vld_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: one instance with MAX_HOLD=4, one with MAX_HOLD=16.
// Outputs are packed as {gnt, gnt_idx, gnt_valid, timeout} and checked on the falling edge.
module tb_rr_arbiter_4;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  rr_arbiter_4_if b4 ();
  rr_arbiter_4_if b16 ();

  rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(5)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.slave)
  );

  rr_arbiter_4 #(.MAX_HOLD(16), .CNT_W(5)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  wire [7:0] o4  = {b4.gnt, b4.gnt_idx, b4.gnt_valid, b4.timeout};
  wire [7:0] o16 = {b16.gnt, b16.gnt_idx, b16.gnt_valid, b16.timeout};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ex(input int owner, input logic to);
    logic [3:0] oh;
    logic [1:0] ix;
    if (owner < 0) return 8'h00;
    ix = owner[1:0];
    oh = 4'b0001 << ix;
    return {oh, ix, 1'b1, to};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    rst     = 1'b1;
    b4.req  = 4'b0000;
    b16.req = 4'b0000;

    #12;
    chk("reset_u4", o4, ex(-1, 1'b0));
    chk("reset_u16", o16, ex(-1, 1'b0));

    // Single requester on client 2 for five cycles
    @(negedge clk);
    rst     = 1'b0;
    b16.req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("single_c2_%0d", i), o16, ex(2, 1'b0));
    end
    b16.req = 4'b0000;
    @(negedge clk);
    chk("single_drop", o16, ex(-1, 1'b0));
    chk("u4_still_idle", o4, ex(-1, 1'b0));

    // Release handover 0 -> 1 with no bubble, then hold counter restart
    b16.req = 4'b0011;
    @(negedge clk);
    chk("rel_c0_a", o16, ex(0, 1'b0));
    @(negedge clk);
    chk("rel_c0_b", o16, ex(0, 1'b0));
    b16.req = 4'b0010;
    @(negedge clk);
    chk("rel_to_c1", o16, ex(1, 1'b0));
    b16.req = 4'b0011;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("rel_hold_c1_%0d", i), o16, ex(1, 1'b0));
    end
    @(negedge clk);
    chk("rel_rotate_c0", o16, ex(0, 1'b1));
    @(negedge clk);
    chk("rel_c0_to_clear", o16, ex(0, 1'b0));
    b16.req = 4'b0000;
    @(negedge clk);
    chk("rel_idle", o16, ex(-1, 1'b0));

    // Client 3 alone for 40 cycles: no timeout past saturation
    b16.req = 4'b1000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("alone_c3_%0d", i), o16, ex(3, 1'b0));
    end
    b16.req = 4'b1010;
    @(negedge clk);
    chk("alone_rotate_c1", o16, ex(1, 1'b1));
    @(negedge clk);
    chk("alone_c1_to_clear", o16, ex(1, 1'b0));

    // Priority wrap: client 3 releases with 0 and 2 pending -> client 0
    b16.req = 4'b1000;
    @(negedge clk);
    chk("wrap_c3", o16, ex(3, 1'b0));
    b16.req = 4'b1101;
    @(negedge clk);
    chk("wrap_c3_hold", o16, ex(3, 1'b0));
    b16.req = 4'b0101;
    @(negedge clk);
    chk("wrap_to_c0", o16, ex(0, 1'b0));
    b16.req = 4'b0000;

    // Full contention with MAX_HOLD=4 from reset priority
    b4.req = 4'b1111;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("rr4_k%0d", k), o4, ex((k / 4) % 4, (k % 4 == 0) && (k > 0)));
    end

    // Asynchronous reset mid-cycle while client 1 owns
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_u4", o4, ex(-1, 1'b0));
    @(negedge clk);
    chk("rst_held_u4", o4, ex(-1, 1'b0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_c0", o4, ex(0, 1'b0));
    chk("post_rst_u16_idle", o16, ex(-1, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
